pc_gen: RTL
===========

Name: pc_gen

Overview:
- Producer end of the PC pipeline path. Generates the fetch PC that the PC pipeline register (flush/stall-aware deliver stage) captures.
- Holds the architectural fetch PC and advances it sequentially.
- Applies redirects from commit/exception flush and from the branch predictor.
- Presents each PC with a valid/ready handshake toward instruction fetch and the downstream PC pipeline register.

Parameters:
- ADDR_WIDTH, 32, width of PC (matches `ADDR_BUS_WIDTH).
- RESET_PC, 32'hbfc00000, PC loaded on reset (boot vector).
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  pipeline flush from commit/exception
- flush_pc  input  ADDR_WIDTH  flush target
- bp_redirect  input  1  predictor taken-redirect
- bp_pc  input  ADDR_WIDTH  predicted target
- stall_next_stage  input  1  downstream PC register cannot accept
- if_ready  input  1  fetch unit can accept a request this cycle
- pc_valid  output  1  pc_out is a live fetch request
- pc_out  output  ADDR_WIDTH  current fetch PC
- pc_misaligned  output  1  pc_out[1:0] != 0 (valid only with pc_valid)
- pc_accept  output  1  handshake fired this cycle

Behaviour:
- One clock. Asynchronous active-high reset; all state is registered.
- State machine, state register width 2:
  - S_RESET: entered asynchronously on rst; pc_valid=0; moves to S_RUN on the first clk edge after rst deasserts.
  - S_RUN: pc_valid=1.
  - S_BUBBLE: one cycle with pc_valid=0 after a flush; always returns to S_RUN.
- Reset values: pc_out=RESET_PC, pc_valid=0, pc_misaligned=0, pc_accept=0, state=S_RESET.
- Handshake:
  - pc_accept = pc_valid & if_ready & ~stall_next_stage & ~flush (combinational).
  - pc_out is held stable while pc_valid=1 and pc_accept=0.
- Next-PC priority, evaluated each cycle; all take effect at the next edge:
  1. flush: pc<=flush_pc; state<=S_BUBBLE. Takes effect in any state, including S_RESET after deassert and S_BUBBLE. Any un-accepted PC is discarded.
  2. bp_redirect (no flush): pc<=bp_pc; state stays/goes S_RUN. Takes effect whether or not the current PC was accepted; an unaccepted current PC is dropped.
  3. pc_accept: pc<=pc+PC_STEP, modulo 2^ADDR_WIDTH. 32'hfffffffc wraps to 0.
  4. Otherwise: hold.
- In S_RESET or S_BUBBLE with no flush, pc holds and state goes to S_RUN.
- Latency: redirect to new pc_out is 1 cycle. Flush to first valid new PC is 2 cycles.
- pc_misaligned = pc_valid & (pc_out[1:0] != 0), registered alongside pc_out. A misaligned PC is still issued (exception raised downstream), then advanced by PC_STEP on accept.
- Simultaneous flush and bp_redirect: flush wins; bp_pc is ignored.
- Simultaneous stall_next_stage and if_ready: no accept; PC holds.
- rst asserted mid-operation: immediate return to reset values regardless of handshake.

Decomposition:
- Shared bus header supplies ADDR_BUS / ADDR_BUS_WIDTH; RESET_PC default lives there as a `define.
- State encodings (S_RESET=2'd0, S_RUN=2'd1, S_BUBBLE=2'd2) are local parameters.
- No sub-module: the next-PC mux and FSM are small.
- The downstream flush/stall pipeline register is a separate existing block, not instantiated here.

Test Plan:
1. Reset then if_ready=1, stall_next_stage=0 for 4 cycles -> cycle after rst: pc_valid=0, pc_out=bfc00000. Then accepts bfc00000, bfc00004, bfc00008, bfc0000c.
2. stall_next_stage=1 for 3 cycles at pc=bfc00008 -> pc_out holds bfc00008, pc_accept=0. Release -> next pc bfc0000c.
3. flush=1 with flush_pc=bfc00380 and bp_redirect=1 with bp_pc=80001000 in the same cycle -> next cycle pc_valid=0, pc_out=bfc00380. Following cycle pc_valid=1, pc_out=bfc00380.
4. bp_redirect=1, bp_pc=80000040 while if_ready=0 -> next cycle pc_out=80000040, pc_valid=1. Old PC never accepted.
5. flush_pc=80000002 -> after bubble, pc_misaligned=1 with pc_out=80000002. On accept, next pc=80000006.
6. bp_pc=fffffffc, accept -> next pc_out=00000000. Then assert rst mid-stall -> immediately pc_out=bfc00000, pc_valid=0.

Source files
------------

// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared address-bus defines and PC-generator state encodings.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif

`ifndef ADDR_BUS
`define ADDR_BUS `ADDR_BUS_WIDTH-1:0
`endif

`ifndef RESET_PC
`define RESET_PC 32'hbfc00000
`endif

package pc_gen_pkg;

    localparam logic [1:0] S_RESET  = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_BUBBLE = 2'd2;

    // Instruction fetch needs word alignment; any low-bit set is a fault.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage : pc_gen_pkg

`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Fetch-PC generator with flush/predictor redirect and
//               valid/ready handshake toward fetch and the PC pipe register.
// Revision    : 1.0 - initial release
// ============================================================================

module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH = `ADDR_BUS_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(`RESET_PC),
    parameter int                    PC_STEP    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  bp_redirect,
    input  logic [ADDR_WIDTH-1:0] bp_pc,
    input  logic                  stall_next_stage,
    input  logic                  if_ready,
    output logic                  pc_valid,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  pc_misaligned,
    output logic                  pc_accept
);

    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP = ADDR_WIDTH'(PC_STEP);

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_misaligned;
    logic                  w_misaligned_nxt;
    logic                  w_valid;
    logic                  w_accept;

    assign w_valid  = (r_state == S_RUN);
    assign w_accept = w_valid & if_ready & ~stall_next_stage & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RESET;
            r_pc         <= RESET_PC;
            r_misaligned <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_misaligned <= w_misaligned_nxt;
        end
    end

    // Redirect priority: flush beats predictor beats sequential advance.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        if (flush) begin
            w_pc_nxt    = flush_pc;
            w_state_nxt = S_BUBBLE;
        end else if (bp_redirect) begin
            w_pc_nxt    = bp_pc;
            w_state_nxt = S_RUN;
        end else begin
            if (w_accept) begin
                w_pc_nxt = r_pc + C_PC_STEP;
            end
            w_state_nxt = S_RUN;
        end
        w_misaligned_nxt = (w_state_nxt == S_RUN) && is_misaligned(w_pc_nxt[1:0]);
    end

    assign pc_valid      = w_valid;
    assign pc_out        = r_pc;
    assign pc_misaligned = r_misaligned;
    assign pc_accept     = w_accept;

endmodule : pc_gen

`default_nettype wire
